// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester link: framing byte defaults and sequencer states.
package manchester_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] PREAMBLE_BYTE_DEFAULT = 8'hAA;
    localparam logic [BYTE_W-1:0] SFD_BYTE_DEFAULT      = 8'hD5;
    localparam logic [BYTE_W-1:0] PAD_BYTE_DEFAULT      = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        PAYLOAD,
        PAD,
        DRAIN,
        GAP
    } seq_state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register: reloads whenever empty or being drained.
module axis_out_reg
    import manchester_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [BYTE_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [BYTE_W-1:0] data,
    output logic              can_load_c
);

    // A held byte only leaves on a completed handshake, so data stays put while stalled
    assign can_load_c = !valid || ready;

    // Output register; data only changes when a new byte is actually loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (can_load_c) begin
            valid <= load_valid;
            if (load_valid) begin
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/manchester_frame_sequencer.sv
// Wraps host payload frames as preamble + SFD + fixed-size payload + idle gap,
// padding short frames and truncating long ones.
module manchester_frame_sequencer
    import manchester_pkg::*;
#(
    parameter int unsigned       FRAME_SIZE    = 4,
    parameter int unsigned       PREAMBLE_LEN  = 2,
    parameter logic [BYTE_W-1:0] PREAMBLE_BYTE = PREAMBLE_BYTE_DEFAULT,
    parameter logic [BYTE_W-1:0] SFD_BYTE      = SFD_BYTE_DEFAULT,
    parameter logic [BYTE_W-1:0] PAD_BYTE      = PAD_BYTE_DEFAULT,
    parameter int unsigned       GAP_CYCLES    = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [BYTE_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [BYTE_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              frame_done,
    output logic              err_short,
    output logic              err_long,
    output logic [15:0]       frame_count
);

    localparam int unsigned BYTE_CNT_W = $clog2(FRAME_SIZE + 1);
    localparam int unsigned PRE_CNT_W  = $clog2(PREAMBLE_LEN + 1);
    localparam int unsigned GAP_CNT_W  = $clog2(GAP_CYCLES + 1);

    // Counter values at which the current load is the final one of its section
    localparam logic [BYTE_CNT_W-1:0] BYTE_LAST = BYTE_CNT_W'(FRAME_SIZE - 1);
    localparam logic [PRE_CNT_W-1:0]  PRE_LAST  = PRE_CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [GAP_CNT_W-1:0]  GAP_LAST  = GAP_CNT_W'(GAP_CYCLES - 1);

    seq_state_t state, state_nxt;

    logic [BYTE_CNT_W-1:0] byte_cnt, byte_cnt_nxt;
    logic [PRE_CNT_W-1:0]  pre_cnt, pre_cnt_nxt;
    logic [GAP_CNT_W-1:0]  gap_cnt, gap_cnt_nxt;

    logic              tlast_seen, tlast_seen_nxt;
    logic              last_in_reg;
    logic              load_valid;
    logic              load_last;
    logic [BYTE_W-1:0] load_data;
    logic              can_load;
    logic              m_hs;
    logic              frame_end;
    logic              drain_end;
    logic              frame_out;
    logic              err_short_nxt;
    logic              err_long_nxt;

    axis_out_reg u_out_reg (
        .clk        (aclk),
        .rst        (areset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .ready      (m_axis_tready),
        .valid      (m_axis_tvalid),
        .data       (m_axis_tdata),
        .can_load_c (can_load)
    );

    assign m_hs      = m_axis_tvalid && m_axis_tready;
    assign frame_end = m_hs && last_in_reg;

    // Next-state, counter and load decisions
    always_comb begin
        state_nxt      = state;
        byte_cnt_nxt   = byte_cnt;
        pre_cnt_nxt    = pre_cnt;
        gap_cnt_nxt    = gap_cnt;
        tlast_seen_nxt = tlast_seen;
        load_valid     = 1'b0;
        load_last      = 1'b0;
        load_data      = PAD_BYTE;
        s_axis_tready  = 1'b0;
        err_short_nxt  = 1'b0;
        err_long_nxt   = 1'b0;
        drain_end      = 1'b0;
        frame_out      = 1'b0;

        case (state)
            // First preamble byte is loaded on the cycle the host shows data
            IDLE: begin
                if (s_axis_tvalid && can_load) begin
                    load_valid = 1'b1;
                    load_data  = PREAMBLE_BYTE;
                    if (pre_cnt == PRE_LAST) begin
                        pre_cnt_nxt = '0;
                        state_nxt   = SFD;
                    end else begin
                        pre_cnt_nxt = pre_cnt + PRE_CNT_W'(1);
                        state_nxt   = PREAMBLE;
                    end
                end
            end

            PREAMBLE: begin
                if (can_load) begin
                    load_valid = 1'b1;
                    load_data  = PREAMBLE_BYTE;
                    if (pre_cnt == PRE_LAST) begin
                        pre_cnt_nxt = '0;
                        state_nxt   = SFD;
                    end else begin
                        pre_cnt_nxt = pre_cnt + PRE_CNT_W'(1);
                    end
                end
            end

            SFD: begin
                if (can_load) begin
                    load_valid   = 1'b1;
                    load_data    = SFD_BYTE;
                    byte_cnt_nxt = '0;
                    state_nxt    = PAYLOAD;
                end
            end

            // Once the final byte sits in the output register, wait for its handshake
            PAYLOAD: begin
                if (last_in_reg) begin
                    if (m_hs) begin
                        byte_cnt_nxt = '0;
                        state_nxt    = GAP;
                    end
                end else begin
                    s_axis_tready = can_load;
                    if (s_axis_tvalid && can_load) begin
                        load_valid   = 1'b1;
                        load_data    = s_axis_tdata;
                        byte_cnt_nxt = byte_cnt + BYTE_CNT_W'(1);
                        if (byte_cnt == BYTE_LAST) begin
                            load_last = 1'b1;
                            if (!s_axis_tlast) begin
                                err_long_nxt = 1'b1;
                                state_nxt    = DRAIN;
                            end
                        end else if (s_axis_tlast) begin
                            err_short_nxt = 1'b1;
                            state_nxt     = PAD;
                        end
                    end
                end
            end

            PAD: begin
                if (last_in_reg) begin
                    if (m_hs) begin
                        byte_cnt_nxt = '0;
                        state_nxt    = GAP;
                    end
                end else if (can_load) begin
                    load_valid   = 1'b1;
                    load_data    = PAD_BYTE;
                    byte_cnt_nxt = byte_cnt + BYTE_CNT_W'(1);
                    load_last    = (byte_cnt == BYTE_LAST);
                end
            end

            // Swallow surplus bytes through tlast; the truncated frame still drains out
            DRAIN: begin
                s_axis_tready = !tlast_seen;
                drain_end     = tlast_seen || (s_axis_tvalid && s_axis_tlast);
                frame_out     = !last_in_reg || m_hs;
                if (drain_end && frame_out) begin
                    tlast_seen_nxt = 1'b0;
                    byte_cnt_nxt   = '0;
                    state_nxt      = GAP;
                end else if (drain_end) begin
                    tlast_seen_nxt = 1'b1;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_CNT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and status pulses
    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            pre_cnt     <= '0;
            gap_cnt     <= '0;
            tlast_seen  <= 1'b0;
            last_in_reg <= 1'b0;
            frame_done  <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            frame_count <= '0;
        end else begin
            state      <= state_nxt;
            byte_cnt   <= byte_cnt_nxt;
            pre_cnt    <= pre_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            tlast_seen <= tlast_seen_nxt;
            err_short  <= err_short_nxt;
            err_long   <= err_long_nxt;
            frame_done <= frame_end;
            if (can_load) begin
                last_in_reg <= load_valid && load_last;
            end
            if (frame_end) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule
